// File: rtl/vga_plot_arbiter_if.sv
// Requester-side pixel bus for vga_plot_arbiter: four packed requesters plus the one-hot grant back.
interface vga_plot_arbiter_if;
  logic [3:0]  req;
  logic [35:0] req_x;
  logic [31:0] req_y;
  logic [11:0] req_color;
  logic [3:0]  gnt;

  modport master (output req, output req_x, output req_y, output req_color, input gnt);
  modport slave  (input req, input req_x, input req_y, input req_color, output gnt);
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin burst arbiter feeding one registered VGA pixel-write port; background repaint has top priority.
// Optional burst length cap enabled with macro PLOT_ARB_BURST_LIMIT_EN.
module vga_plot_arbiter #(
  parameter logic [10:0] MAX_BURST = 11'd1024
) (
  input  logic              CLOCK_50,
  input  logic              rstn,
  input  logic              bg_mode,
  input  logic [8:0]        bg_x,
  input  logic [7:0]        bg_y,
  input  logic [2:0]        bg_color,
  vga_plot_arbiter_if.slave bus,
  output logic [8:0]        VGA_X,
  output logic [7:0]        VGA_Y,
  output logic [2:0]        VGA_COLOR,
  output logic              plot_enable,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, BG = 2'd2} state_t;

  state_t      state_r, next_state_s;
  logic [1:0]  owner_r, next_owner_s, last_owner_r;
  logic [3:0]  gnt_r, gnt_next_s;
  logic        accept_s, release_s, limit_hit_s, busy_r, busy_next_s;
  logic [8:0]  x_sel_s, vga_x_r, x_next_s;
  logic [7:0]  y_sel_s, vga_y_r, y_next_s;
  logic [2:0]  c_sel_s, vga_c_r, c_next_s;
  logic        plot_r, plot_next_s;

  // First set request bit searching upward from last+1, wrapping mod 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  assign accept_s = (state_r == BURST) && bus.req[owner_r] && gnt_r[owner_r];
  assign x_sel_s  = bus.req_x[32'(owner_r) * 32'd9 +: 9];
  assign y_sel_s  = bus.req_y[32'(owner_r) * 32'd8 +: 8];
  assign c_sel_s  = bus.req_color[32'(owner_r) * 32'd3 +: 3];

`ifdef PLOT_ARB_BURST_LIMIT_EN
  logic [10:0] burst_cnt_r;

  assign limit_hit_s = accept_s && (burst_cnt_r == (MAX_BURST - 11'd1));

  // Burst length counter: cleared on each new grant, saturates instead of wrapping.
  always_ff @(posedge CLOCK_50 or negedge rstn) begin
    if (!rstn) begin
      burst_cnt_r <= 11'd0;
    end else if ((state_r == IDLE) && (next_state_s == BURST)) begin
      burst_cnt_r <= 11'd0;
    end else if (accept_s && (burst_cnt_r != 11'h7FF)) begin
      burst_cnt_r <= burst_cnt_r + 11'd1;
    end else begin
      burst_cnt_r <= burst_cnt_r;
    end
  end
`else
  logic unused_max_burst_s;

  assign unused_max_burst_s = ^MAX_BURST;
  assign limit_hit_s        = 1'b0;
`endif

  // State register with current and previous burst owner.
  always_ff @(posedge CLOCK_50 or negedge rstn) begin
    if (!rstn) begin
      state_r      <= IDLE;
      owner_r      <= 2'd0;
      last_owner_r <= 2'd3;
    end else begin
      state_r      <= next_state_s;
      owner_r      <= next_owner_s;
      last_owner_r <= release_s ? owner_r : last_owner_r;
    end
  end

  // Next-state logic; a release and a limit hit in the same cycle collapse into one release.
  always_comb begin
    next_state_s = state_r;
    next_owner_s = owner_r;
    release_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bg_mode) begin
          next_state_s = BG;
        end else if (|bus.req) begin
          next_state_s = BURST;
          next_owner_s = rr_pick(bus.req, last_owner_r);
        end else begin
          next_state_s = IDLE;
        end
      end
      BURST: begin
        if (!bus.req[owner_r] || limit_hit_s) begin
          next_state_s = IDLE;
          release_s    = 1'b1;
        end else begin
          next_state_s = BURST;
        end
      end
      BG: begin
        if (!bg_mode) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = BG;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Output decode: next grant, busy flag and the pixel to register.
  always_comb begin
    gnt_next_s  = 4'b0000;
    busy_next_s = (next_state_s != IDLE);
    plot_next_s = 1'b0;
    x_next_s    = vga_x_r;
    y_next_s    = vga_y_r;
    c_next_s    = vga_c_r;
    if (next_state_s == BURST) begin
      gnt_next_s = 4'b0001 << next_owner_s;
    end else begin
      gnt_next_s = 4'b0000;
    end
    if (accept_s) begin
      plot_next_s = 1'b1;
      x_next_s    = x_sel_s;
      y_next_s    = y_sel_s;
      c_next_s    = c_sel_s;
    end else if ((state_r == BG) && bg_mode) begin
      plot_next_s = 1'b1;
      x_next_s    = bg_x;
      y_next_s    = bg_y;
      c_next_s    = bg_color;
    end else begin
      plot_next_s = 1'b0;
    end
  end

  // Registered outputs.
  always_ff @(posedge CLOCK_50 or negedge rstn) begin
    if (!rstn) begin
      gnt_r   <= 4'b0000;
      busy_r  <= 1'b0;
      plot_r  <= 1'b0;
      vga_x_r <= 9'd0;
      vga_y_r <= 8'd0;
      vga_c_r <= 3'd0;
    end else begin
      gnt_r   <= gnt_next_s;
      busy_r  <= busy_next_s;
      plot_r  <= plot_next_s;
      vga_x_r <= x_next_s;
      vga_y_r <= y_next_s;
      vga_c_r <= c_next_s;
    end
  end

  assign bus.gnt     = gnt_r;
  assign busy        = busy_r;
  assign plot_enable = plot_r;
  assign VGA_X       = vga_x_r;
  assign VGA_Y       = vga_y_r;
  assign VGA_COLOR   = vga_c_r;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter: directed stimulus pushes expected pixels, a negedge monitor pops them.
module tb_vga_plot_arbiter;

  logic       CLOCK_50 = 1'b0;
  logic       rstn;
  logic       bg_mode;
  logic [8:0] bg_x;
  logic [7:0] bg_y;
  logic [2:0] bg_color;
  logic [8:0] VGA_X;
  logic [7:0] VGA_Y;
  logic [2:0] VGA_COLOR;
  logic       plot_enable;
  logic       busy;

  vga_plot_arbiter_if bus();

  vga_plot_arbiter #(.MAX_BURST(11'd4)) dut (
    .CLOCK_50    (CLOCK_50),
    .rstn        (rstn),
    .bg_mode     (bg_mode),
    .bg_x        (bg_x),
    .bg_y        (bg_y),
    .bg_color    (bg_color),
    .bus         (bus),
    .VGA_X       (VGA_X),
    .VGA_Y       (VGA_Y),
    .VGA_COLOR   (VGA_COLOR),
    .plot_enable (plot_enable),
    .busy        (busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
    int         cyc;
  } pix_t;

  pix_t exp_q[$];
  pix_t mon_p;
  int   tests   = 0;
  int   fails   = 0;
  int   cyc_cnt = 0;

  always @(posedge CLOCK_50) cyc_cnt <= cyc_cnt + 1;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic set_pix(input int i, input logic [8:0] x, input logic [7:0] y, input logic [2:0] c);
    bus.req_x[9*i +: 9]     = x;
    bus.req_y[8*i +: 8]     = y;
    bus.req_color[3*i +: 3] = c;
  endtask

  // Pixel accepted at the coming edge must show on the outputs right after it.
  task automatic push_exp(input logic [8:0] x, input logic [7:0] y, input logic [2:0] c);
    pix_t p;
    p.x   = x;
    p.y   = y;
    p.c   = c;
    p.cyc = cyc_cnt + 1;
    exp_q.push_back(p);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every plot must match the head of the scoreboard in data and cycle.
  always @(negedge CLOCK_50) begin
    if (rstn === 1'b1) begin
      if (plot_enable === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d at cycle %0d, expected no plot",
                   VGA_X, VGA_Y, VGA_COLOR, cyc_cnt);
        end else begin
          mon_p = exp_q.pop_front();
          if (VGA_X !== mon_p.x || VGA_Y !== mon_p.y || VGA_COLOR !== mon_p.c || cyc_cnt != mon_p.cyc) begin
            fails++;
            $display("FAIL pixel: got x=%0d y=%0d c=%0d cyc=%0d expected x=%0d y=%0d c=%0d cyc=%0d",
                     VGA_X, VGA_Y, VGA_COLOR, cyc_cnt, mon_p.x, mon_p.y, mon_p.c, mon_p.cyc);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
        tests++;
        fails++;
        mon_p = exp_q.pop_front();
        $display("FAIL missing_plot: got plot_enable=%0b at cycle %0d expected x=%0d y=%0d c=%0d",
                 plot_enable, cyc_cnt, mon_p.x, mon_p.y, mon_p.c);
      end
    end
  end

  initial begin
    rstn          = 1'b0;
    bg_mode       = 1'b0;
    bg_x          = 9'd0;
    bg_y          = 8'd0;
    bg_color      = 3'd0;
    bus.req       = 4'b0000;
    bus.req_x     = 36'd0;
    bus.req_y     = 32'd0;
    bus.req_color = 12'd0;
    tick();
    tick();
    chk("rst_gnt",  32'(bus.gnt), 32'd0);
    chk("rst_plot", 32'(plot_enable), 32'd0);
    chk("rst_xyc",  32'({VGA_X, VGA_Y, VGA_COLOR}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rstn = 1'b1;

    // Requester 0 first after reset, then requester 1 after one idle cycle.
    set_pix(0, 9'd10, 8'd20, 3'd1);
    set_pix(1, 9'd11, 8'd21, 3'd2);
    bus.req = 4'b0011;
    chk("idle_gnt", 32'(bus.gnt), 32'd0);
    tick();
    chk("gnt_first_r0", 32'(bus.gnt), 32'b0001);
    chk("busy_burst", 32'(busy), 32'd1);
    push_exp(9'd10, 8'd20, 3'd1);
    tick();
    chk("gnt_hold_r0", 32'(bus.gnt), 32'b0001);
    set_pix(0, 9'd12, 8'd22, 3'd3);
    push_exp(9'd12, 8'd22, 3'd3);
    tick();
    bus.req = 4'b0010;
    tick();
    chk("idle_between", 32'(bus.gnt), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    tick();
    chk("gnt_second_r1", 32'(bus.gnt), 32'b0010);
    push_exp(9'd11, 8'd21, 3'd2);
    tick();
    bus.req = 4'b0000;
    tick();

    // Owner 2 single pixel, latency 1, then plot_enable low after release.
    set_pix(2, 9'd100, 8'd50, 3'b101);
    bus.req = 4'b0100;
    tick();
    chk("gnt_r2", 32'(bus.gnt), 32'b0100);
    push_exp(9'd100, 8'd50, 3'b101);
    tick();
    bus.req = 4'b0000;
    tick();
    chk("plot_after_drop", 32'(plot_enable), 32'd0);

    // Round-robin wrap: last owner 2, requests 3/1/0 -> owner 3.
    set_pix(3, 9'd200, 8'd100, 3'd7);
    bus.req = 4'b1011;
    tick();
    chk("gnt_rr_wrap_r3", 32'(bus.gnt), 32'b1000);
    push_exp(9'd200, 8'd100, 3'd7);
    tick();
    bus.req = 4'b0000;
    tick();

    // Background request mid-burst of owner 1 waits for the burst, then streams.
    set_pix(1, 9'd30, 8'd40, 3'd6);
    bus.req = 4'b0010;
    tick();
    chk("gnt_r1_bg", 32'(bus.gnt), 32'b0010);
    push_exp(9'd30, 8'd40, 3'd6);
    bg_mode  = 1'b1;
    bg_x     = 9'd1;
    bg_y     = 8'd2;
    bg_color = 3'd3;
    tick();
    chk("no_preempt", 32'(bus.gnt), 32'b0010);
    push_exp(9'd30, 8'd40, 3'd6);
    tick();
    bus.req = 4'b0000;
    tick();
    chk("idle_before_bg", 32'(bus.gnt), 32'd0);
    set_pix(0, 9'd60, 8'd70, 3'd4);
    bus.req = 4'b0001;
    tick();
    chk("bg_holdoff", 32'(bus.gnt), 32'd0);
    chk("bg_busy", 32'(busy), 32'd1);
    push_exp(9'd1, 8'd2, 3'd3);
    tick();
    bg_x = 9'd5; bg_y = 8'd6; bg_color = 3'd7;
    push_exp(9'd5, 8'd6, 3'd7);
    tick();
    bg_x = 9'd8; bg_y = 8'd9; bg_color = 3'd0;
    push_exp(9'd8, 8'd9, 3'd0);
    chk("bg_holdoff2", 32'(bus.gnt), 32'd0);
    tick();
    bg_mode = 1'b0;
    tick();
    tick();
    chk("gnt_after_bg_r0", 32'(bus.gnt), 32'b0001);
    push_exp(9'd60, 8'd70, 3'd4);
    tick();
    bus.req = 4'b0000;
    tick();

    // Reset pulsed mid-burst of owner 2.
    set_pix(2, 9'd7, 8'd8, 3'd1);
    bus.req = 4'b0100;
    tick();
    chk("gnt_r2_pre_rst", 32'(bus.gnt), 32'b0100);
    push_exp(9'd7, 8'd8, 3'd1);
    tick();
    set_pix(2, 9'd9, 8'd9, 3'd2);
    tick();
    rstn = 1'b0;
    #1;
    chk("midrst_gnt",  32'(bus.gnt), 32'd0);
    chk("midrst_plot", 32'(plot_enable), 32'd0);
    chk("midrst_xyc",  32'({VGA_X, VGA_Y, VGA_COLOR}), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    set_pix(1, 9'd33, 8'd44, 3'd3);
    bus.req = 4'b0011;
    tick();
    rstn = 1'b1;
    tick();
    chk("gnt_after_rst_r0", 32'(bus.gnt), 32'b0001);

    // Burst cap (MAX_BURST=4) when enabled, otherwise owner 0 keeps plotting.
    for (int k = 0; k < 4; k++) begin
      chk("gnt_burst_r0", 32'(bus.gnt), 32'b0001);
      set_pix(0, 9'(300 + k), 8'(150 + k), 3'(k));
      push_exp(9'(300 + k), 8'(150 + k), 3'(k));
      tick();
    end
`ifdef PLOT_ARB_BURST_LIMIT_EN
    chk("limit_idle", 32'(bus.gnt), 32'd0);
    tick();
    chk("limit_next_r1", 32'(bus.gnt), 32'b0010);
    push_exp(9'd33, 8'd44, 3'd3);
    tick();
    bus.req = 4'b0000;
`else
    for (int k = 4; k < 8; k++) begin
      chk("gnt_nolimit_r0", 32'(bus.gnt), 32'b0001);
      set_pix(0, 9'(300 + k), 8'(150 + k), 3'(k));
      push_exp(9'(300 + k), 8'(150 + k), 3'(k));
      tick();
    end
    bus.req = 4'b0000;
`endif
    tick();
    tick();
    tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
